// File: rtl/debug_pkg.sv
// Definitions shared between the debug controller and the MCU-side responder:
// command function codes, responder FSM states and the strobe decoder.
package debug_pkg;

  typedef enum logic [2:0] {
    DBG_NONE   = 3'd0,
    DBG_PAUSE  = 3'd1,
    DBG_RESUME = 3'd2,
    DBG_RESET  = 3'd3,
    DBG_REG_RD = 3'd4,
    DBG_REG_WR = 3'd5,
    DBG_MEM_RD = 3'd6,
    DBG_MEM_WR = 3'd7
  } DEBUG_FN;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    PAUSED    = 3'd1,
    HALT_WAIT = 3'd2,
    MEM_REQ   = 3'd3,
    MEM_WAIT  = 3'd4,
    REG_ACC   = 3'd5,
    RST_HOLD  = 3'd6,
    DONE      = 3'd7
  } resp_state_e;

  // Strobe order {mem_wr, mem_rd, reg_wr, reg_rd, dbg_reset, resume, pause};
  // zero or several strobes decode to DBG_NONE.
  function automatic DEBUG_FN decode_fn(input logic [6:0] strb);
    DEBUG_FN fn;
    case (strb)
      7'b0000001: fn = DBG_PAUSE;
      7'b0000010: fn = DBG_RESUME;
      7'b0000100: fn = DBG_RESET;
      7'b0001000: fn = DBG_REG_RD;
      7'b0010000: fn = DBG_REG_WR;
      7'b0100000: fn = DBG_MEM_RD;
      7'b1000000: fn = DBG_MEM_WR;
      default:    fn = DBG_NONE;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/mcu_debug_responder.sv
// MCU-side debug command responder: halts, resumes and resets the core, and
// performs memory / register-file accesses for the debugger while paused.
module mcu_debug_responder
  import debug_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        dbg_reset,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic        mcu_busy,
  output logic [31:0] d_rd,
  output logic        error,
  output logic        cpu_halt_req,
  input  logic        cpu_halted,
  output logic        cpu_reset,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  input  logic [31:0] rf_rdata
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > MEM_TIMEOUT) ? RST_CYCLES : MEM_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  // MEM_WAIT begins the cycle after mem_req, leaving MEM_TIMEOUT-1 cycles to see mem_ready.
  localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'((MEM_TIMEOUT > 1) ? (MEM_TIMEOUT - 2) : 0);

  resp_state_e      state_q, state_d;
  DEBUG_FN          fn_q, fn_d, fn_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             accept_s, reg_ok_s, mem_ok_s;

  logic        busy_q, busy_d, error_q, error_d, halt_q, halt_d, cpu_reset_q, cpu_reset_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, rf_we_q, rf_we_d;
  logic [31:0] d_rd_q, d_rd_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic [4:0]  rf_addr_q, rf_addr_d;

  assign fn_s     = decode_fn({mem_wr, mem_rd, reg_wr, reg_rd, dbg_reset, resume, pause});
  assign accept_s = valid && !busy_q;
  assign reg_ok_s = (state_q == PAUSED) && (addr[31:5] == 27'd0);
  assign mem_ok_s = (state_q == PAUSED) && (addr[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      fn_q        <= DBG_NONE;
      cnt_q       <= {CNT_W{1'b0}};
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      d_rd_q      <= 32'd0;
      error_q     <= 1'b0;
      halt_q      <= 1'b0;
      cpu_reset_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      rf_addr_q   <= 5'd0;
      rf_wdata_q  <= 32'd0;
      rf_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fn_q        <= fn_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      d_rd_q      <= d_rd_d;
      error_q     <= error_d;
      halt_q      <= halt_d;
      cpu_reset_q <= cpu_reset_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_we_q     <= rf_we_d;
    end
  end

  // Every command finishes through DONE or straight out of MEM_WAIT/REG_ACC.
  always_comb begin
    state_d = state_q;
    fn_d    = fn_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      RUN, PAUSED: begin
        if (accept_s) begin
          fn_d    = fn_s;
          err_d   = 1'b0;
          state_d = DONE;
          case (fn_s)
            DBG_PAUSE:  state_d = (state_q == RUN) ? HALT_WAIT : DONE;
            DBG_RESUME: state_d = DONE;
            DBG_RESET: begin
              state_d = RST_HOLD;
              cnt_d   = RST_LOAD;
            end
            DBG_REG_RD, DBG_REG_WR: begin
              if (reg_ok_s) state_d = REG_ACC;
              else          err_d   = 1'b1;
            end
            DBG_MEM_RD, DBG_MEM_WR: begin
              if (mem_ok_s) state_d = MEM_REQ;
              else          err_d   = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      HALT_WAIT: state_d = cpu_halted ? DONE : HALT_WAIT;
      MEM_REQ: begin
        state_d = MEM_WAIT;
        cnt_d   = MEM_LOAD;
      end
      MEM_WAIT: begin
        if (mem_ready || (cnt_q == {CNT_W{1'b0}})) state_d = PAUSED;
        else                                       cnt_d   = cnt_q - CNT_W'(1);
      end
      REG_ACC: state_d = PAUSED;
      RST_HOLD: begin
        if (cnt_q == {CNT_W{1'b0}}) state_d = DONE;
        else                        cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = halt_q ? PAUSED : RUN;
      default: state_d = RUN;
    endcase
  end

  // Registered outputs: next values for every output register.
  always_comb begin
    busy_d      = busy_q;
    d_rd_d      = d_rd_q;
    error_d     = 1'b0;
    halt_d      = halt_q;
    cpu_reset_d = cpu_reset_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_wdata_d  = rf_wdata_q;
    rf_we_d     = 1'b0;
    case (state_q)
      RUN, PAUSED: begin
        if (accept_s) begin
          busy_d = 1'b1;
          case (fn_s)
            DBG_PAUSE:  halt_d = 1'b1;
            DBG_RESUME: halt_d = 1'b0;
            DBG_RESET: begin
              cpu_reset_d = 1'b1;
              halt_d      = 1'b0;
            end
            DBG_REG_RD, DBG_REG_WR: begin
              if (reg_ok_s) begin
                rf_addr_d  = addr[4:0];
                rf_wdata_d = d_in;
                rf_we_d    = (fn_s == DBG_REG_WR) && (addr[4:0] != 5'd0);
              end else begin
                rf_we_d = 1'b0;
              end
            end
            DBG_MEM_RD, DBG_MEM_WR: begin
              if (mem_ok_s) begin
                mem_addr_d  = addr;
                mem_wdata_d = d_in;
                mem_req_d   = 1'b1;
                mem_we_d    = (fn_s == DBG_MEM_WR);
              end else begin
                mem_req_d = 1'b0;
              end
            end
            default: busy_d = 1'b1;
          endcase
        end else begin
          busy_d = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          busy_d = 1'b0;
          d_rd_d = (fn_q == DBG_MEM_RD) ? mem_rdata : d_rd_q;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      REG_ACC: begin
        busy_d = 1'b0;
        if (fn_q == DBG_REG_RD) d_rd_d = (rf_addr_q == 5'd0) ? 32'd0 : rf_rdata;
        else                    d_rd_d = d_rd_q;
      end
      RST_HOLD: cpu_reset_d = (cnt_q != {CNT_W{1'b0}});
      DONE: begin
        busy_d  = 1'b0;
        error_d = err_q;
      end
      default: busy_d = busy_q;
    endcase
  end

  assign mcu_busy     = busy_q;
  assign d_rd         = d_rd_q;
  assign error        = error_q;
  assign cpu_halt_req = halt_q;
  assign cpu_reset    = cpu_reset_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign rf_addr      = rf_addr_q;
  assign rf_wdata     = rf_wdata_q;
  assign rf_we        = rf_we_q;

endmodule

// File: tb/tb_mcu_debug_responder.sv
// Directed bench for mcu_debug_responder: expected completions are queued when
// a command is issued and compared when mcu_busy falls.
module tb_mcu_debug_responder;

  localparam int RST_CYC = 4;
  localparam int MEM_TO  = 255;
  localparam logic [6:0] S_NONE   = 7'b0000000;
  localparam logic [6:0] S_PAUSE  = 7'b0000001;
  localparam logic [6:0] S_RESUME = 7'b0000010;
  localparam logic [6:0] S_DRST   = 7'b0000100;
  localparam logic [6:0] S_REG_RD = 7'b0001000;
  localparam logic [6:0] S_REG_WR = 7'b0010000;
  localparam logic [6:0] S_MEM_RD = 7'b0100000;
  localparam logic [6:0] S_MEM_WR = 7'b1000000;

  logic        clk = 1'b0;
  logic        reset, valid, pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr;
  logic [31:0] addr, d_in;
  logic        mcu_busy, error, cpu_halt_req, cpu_halted, cpu_reset;
  logic [31:0] d_rd, mem_addr, mem_wdata, rf_wdata, rf_rdata;
  logic        mem_req, mem_we, rf_we;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic [4:0]  rf_addr;

  always #5 clk = ~clk;

  mcu_debug_responder #(.RST_CYCLES(RST_CYC), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .reset(reset), .valid(valid), .pause(pause), .resume(resume),
    .dbg_reset(dbg_reset), .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .addr(addr), .d_in(d_in), .mcu_busy(mcu_busy), .d_rd(d_rd),
    .error(error), .cpu_halt_req(cpu_halt_req), .cpu_halted(cpu_halted),
    .cpu_reset(cpu_reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata)
  );

  // Memory model: answers mem_req after mem_lat cycles (mem_lat 0 = never answers).
  int          mem_lat = 2;
  logic        pend = 1'b0;
  int          cd = 0;
  logic        p_we = 1'b0;
  logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
  logic [31:0] mem_arr [0:255];
  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (mem_req && mem_lat != 0) begin
      pend <= 1'b1; cd <= mem_lat - 1; p_addr <= mem_addr; p_wdata <= mem_wdata; p_we <= mem_we;
    end else if (pend) begin
      if (cd < 2) begin
        pend <= 1'b0; mem_ready <= 1'b1;
        if (p_we) mem_arr[p_addr[9:2]] <= p_wdata;
        else      mem_rdata <= mem_arr[p_addr[9:2]];
      end else begin
        cd <= cd - 1;
      end
    end
  end

  // Register-file model; x0 deliberately reads non-zero so the responder must mask it.
  logic [31:0] rf_mem [0:31];
  always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;
  assign rf_rdata = (rf_addr == 5'd0) ? 32'hBAD0_0000 : rf_mem[rf_addr];

  // Pulse counters and burst-length monitors.
  int   err_pulses = 0, rf_we_cnt = 0, mem_req_cnt = 0, busy_len = 0, rst_len = 0;
  logic busy_prev = 1'b0, rst_prev = 1'b0;
  always @(posedge clk) begin
    if (error)   err_pulses  <= err_pulses + 1;
    if (rf_we)   rf_we_cnt   <= rf_we_cnt + 1;
    if (mem_req) mem_req_cnt <= mem_req_cnt + 1;
  end
  always @(negedge clk) begin
    busy_prev <= mcu_busy;
    rst_prev  <= cpu_reset;
    if (mcu_busy)  busy_len <= busy_prev ? busy_len + 1 : 1;
    if (cpu_reset) rst_len  <= rst_prev ? rst_len + 1 : 1;
  end

  typedef struct { logic [31:0] drd; logic err; } exp_t;
  exp_t        sb[$];
  logic [31:0] drd_model;
  int          n_checks = 0, n_pass = 0, n_fail = 0, e0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input logic [31:0] drd, input logic err);
    exp_t e;
    e.drd = drd; e.err = err;
    sb.push_back(e);
  endtask

  task automatic send(input logic [6:0] s, input logic [31:0] a, input logic [31:0] din);
    {mem_wr, mem_rd, reg_wr, reg_rd, dbg_reset, resume, pause} = s;
    addr = a; d_in = din; valid = 1'b1;
    @(negedge clk);
    {mem_wr, mem_rd, reg_wr, reg_rd, dbg_reset, resume, pause} = 7'b0000000;
    valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int bound);
    exp_t e;
    int   n;
    n = 0;
    while (mcu_busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, mcu_busy}, 32'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_err"}, {31'd0, error}, {31'd0, e.err});
      chk({tag, "_drd"}, d_rd, e.drd);
    end else begin
      chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
    end
    @(negedge clk);
    chk({tag, "_err1cyc"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; addr = 32'd0; d_in = 32'd0; cpu_halted = 1'b0;
    {mem_wr, mem_rd, reg_wr, reg_rd, dbg_reset, resume, pause} = 7'b0000000;
    drd_model = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, mcu_busy}, 32'd0);
    chk("rst_drd", d_rd, 32'd0);
    chk("rst_err", {31'd0, error}, 32'd0);
    chk("rst_halt", {31'd0, cpu_halt_req}, 32'd0);
    chk("rst_cpurst", {31'd0, cpu_reset}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_rfwe", {31'd0, rf_we}, 32'd0);
    chk("rst_memaddr", mem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    expect_res(drd_model, 1'b1);
    send(S_REG_RD, 32'd5, 32'd0);
    finish_cmd("run_regrd", 10);
    chk("run_regrd_rfwe", 32'(rf_we_cnt), 32'd0);
    chk("run_regrd_memreq", 32'(mem_req_cnt), 32'd0);

    expect_res(drd_model, 1'b0);
    send(S_RESUME, 32'd0, 32'd0);
    finish_cmd("resume_run", 10);
    chk("resume_run_len", 32'(busy_len), 32'd1);

    expect_res(drd_model, 1'b0);
    send(S_PAUSE, 32'd0, 32'd0);
    chk("pause_busy", {31'd0, mcu_busy}, 32'd1);
    chk("pause_halt_req", {31'd0, cpu_halt_req}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    cpu_halted = 1'b1;
    finish_cmd("pause", 20);
    chk("pause_len", 32'(busy_len), 32'd4);
    chk("paused_halt_req", {31'd0, cpu_halt_req}, 32'd1);

    expect_res(drd_model, 1'b0);
    send(S_PAUSE, 32'd0, 32'd0);
    finish_cmd("pause_again", 10);
    chk("pause_again_len", 32'(busy_len), 32'd1);

    expect_res(drd_model, 1'b0);
    send(S_MEM_WR, 32'h100, 32'hCAFE_F00D);
    chk("memwr_req", {31'd0, mem_req}, 32'd1);
    chk("memwr_we", {31'd0, mem_we}, 32'd1);
    chk("memwr_addr", mem_addr, 32'h100);
    chk("memwr_wdata", mem_wdata, 32'hCAFE_F00D);
    finish_cmd("mem_wr", 20);
    chk("mem_wr_len", 32'(busy_len), 32'd3);

    drd_model = 32'hCAFE_F00D;
    expect_res(drd_model, 1'b0);
    send(S_MEM_RD, 32'h100, 32'd0);
    chk("memrd_req", {31'd0, mem_req}, 32'd1);
    chk("memrd_we", {31'd0, mem_we}, 32'd0);
    finish_cmd("mem_rd", 20);
    chk("mem_no_err", 32'(err_pulses), 32'd1);

    expect_res(drd_model, 1'b1);
    send(S_MEM_RD, 32'h102, 32'd0);
    finish_cmd("mem_misalign", 10);
    chk("mem_misalign_req", 32'(mem_req_cnt), 32'd2);

    expect_res(drd_model, 1'b1);
    send(S_PAUSE | S_RESUME, 32'd0, 32'd0);
    finish_cmd("multi_strobe", 10);
    chk("multi_strobe_halt", {31'd0, cpu_halt_req}, 32'd1);

    expect_res(drd_model, 1'b1);
    send(S_NONE, 32'd0, 32'd0);
    finish_cmd("no_strobe", 10);

    expect_res(drd_model, 1'b0);
    send(S_REG_WR, 32'd0, 32'h1234);
    finish_cmd("reg_wr0", 10);
    chk("reg_wr0_rfwe", 32'(rf_we_cnt), 32'd0);

    expect_res(drd_model, 1'b0);
    send(S_REG_WR, 32'd7, 32'h55);
    chk("reg_wr7_we", {31'd0, rf_we}, 32'd1);
    chk("reg_wr7_addr", {27'd0, rf_addr}, 32'd7);
    chk("reg_wr7_data", rf_wdata, 32'h55);
    finish_cmd("reg_wr7", 10);
    chk("reg_wr7_cnt", 32'(rf_we_cnt), 32'd1);

    drd_model = 32'd0;
    expect_res(drd_model, 1'b0);
    send(S_REG_RD, 32'd0, 32'd0);
    finish_cmd("reg_rd0", 10);

    drd_model = 32'h55;
    expect_res(drd_model, 1'b0);
    send(S_REG_RD, 32'd7, 32'd0);
    finish_cmd("reg_rd7", 10);
    chk("reg_rd7_len", 32'(busy_len), 32'd1);

    expect_res(drd_model, 1'b1);
    send(S_REG_RD, 32'h20, 32'd0);
    finish_cmd("reg_badidx", 10);

    mem_lat = 0;
    expect_res(drd_model, 1'b1);
    send(S_MEM_RD, 32'h200, 32'd0);
    finish_cmd("mem_timeout", MEM_TO + 20);
    chk("mem_timeout_len", 32'(busy_len), 32'(MEM_TO));

    send(S_MEM_RD, 32'h100, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_busy", {31'd0, mcu_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outs", {mcu_busy, error, cpu_halt_req, cpu_reset, mem_req, mem_we, rf_we}, 7'd0);
    chk("abort_drd", d_rd, 32'd0);
    reset = 1'b0;
    e0 = err_pulses;
    repeat (4) @(negedge clk);
    chk("abort_noerr", 32'(err_pulses), 32'(e0));
    chk("abort_idle", {31'd0, mcu_busy}, 32'd0);
    mem_lat = 2;
    drd_model = 32'd0;

    expect_res(drd_model, 1'b0);
    send(S_PAUSE, 32'd0, 32'd0);
    finish_cmd("repause", 10);
    chk("repause_len", 32'(busy_len), 32'd2);

    drd_model = 32'h55;
    expect_res(drd_model, 1'b0);
    send(S_REG_RD, 32'd7, 32'd0);
    finish_cmd("reg_rd7b", 10);

    expect_res(drd_model, 1'b0);
    send(S_DRST, 32'd0, 32'd0);
    chk("dbgrst_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("dbgrst_halt", {31'd0, cpu_halt_req}, 32'd0);
    finish_cmd("dbg_reset", 20);
    chk("dbgrst_rst_len", 32'(rst_len), 32'(RST_CYC));
    chk("dbgrst_busy_len", 32'(busy_len), 32'(RST_CYC + 1));
    chk("dbgrst_cpurst_end", {31'd0, cpu_reset}, 32'd0);

    expect_res(drd_model, 1'b1);
    send(S_REG_RD, 32'd7, 32'd0);
    finish_cmd("run_after_rst", 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
